// File: rtl/mem_arbiter.sv
// Shares the single byte-wide RAM port between instruction fetch and the memory stage.
// Each request is split into byte accesses and read data is reassembled little-endian.
//
// state  | meaning
// S_IDLE | no transaction; RAM port parked at 0; arbitrate requests
// S_XFER | issuing byte addresses and capturing read bytes
// S_DONE | one-cycle done pulse to the served requester
module mem_arbiter #(
  parameter int ADDR_W    = 32,
  parameter bit MEM_FIRST = 1'b1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_done_o,
  output logic [31:0]       if_data_o,
  input  logic              mem_req_i,
  input  logic              mem_we_i,
  input  logic [1:0]        mem_len_i,
  input  logic [ADDR_W-1:0] mem_addr_i,
  input  logic [31:0]       mem_wdata_i,
  output logic              mem_done_o,
  output logic [31:0]       mem_rdata_o,
  input  logic              flush_i,
  output logic              busy_o,
  output logic [ADDR_W-1:0] ram_addr_o,
  output logic              ram_wr_o,
  output logic [7:0]        ram_dout_o,
  input  logic [7:0]        ram_din_i
);

  typedef enum logic [1:0] {S_IDLE = 2'd0, S_XFER = 2'd1, S_DONE = 2'd2} state_t;

  state_t            r_state;
  state_t            w_state_nxt;
  logic              r_is_if;
  logic              r_we;
  logic [2:0]        r_n;
  logic [ADDR_W-1:0] r_base;
  logic [31:0]       r_wdata;
  logic [2:0]        r_issue_cnt;
  logic [2:0]        r_recv_cnt;
  logic [31:0]       r_buf;
  logic              r_addr_vld;
  logic              r_cap;
  logic [31:0]       r_if_data;
  logic [31:0]       r_mem_rdata;
  logic [ADDR_W-1:0] r_ram_addr;
  logic              r_ram_wr;
  logic [7:0]        r_ram_dout;

  logic              w_if_elig;
  logic              w_grant_mem;
  logic              w_grant_if;
  logic              w_grant;
  logic              w_we_sel;
  logic [ADDR_W-1:0] w_base_sel;
  logic [2:0]        w_n_sel;
  logic              w_flush_if;
  logic              w_wr_last;
  logic              w_rd_last;
  logic [7:0]        w_wbyte;
  logic [31:0]       w_buf_nxt;

  // Grants are only acted on in S_IDLE, which also keeps a held req from retriggering in S_DONE.
  always_comb begin
    w_if_elig   = if_req_i & ~flush_i;
    w_grant_mem = mem_req_i & (MEM_FIRST | ~w_if_elig);
    w_grant_if  = w_if_elig & ~w_grant_mem;
    w_grant     = w_grant_mem | w_grant_if;
    w_we_sel    = w_grant_mem & mem_we_i;
    w_base_sel  = w_grant_if ? if_addr_i : mem_addr_i;
    if (w_grant_if)
      w_n_sel = 3'd4;
    else begin
      case (mem_len_i)
        2'b00:   w_n_sel = 3'd1;
        2'b01:   w_n_sel = 3'd2;
        default: w_n_sel = 3'd4;
      endcase
    end
  end

  always_comb begin
    w_flush_if = (r_state == S_XFER) & r_is_if & flush_i;
    w_wr_last  = r_we & (r_issue_cnt == r_n);
    w_rd_last  = ~r_we & r_cap & (r_recv_cnt == (r_n - 3'd1));
    case (r_issue_cnt[1:0])
      2'd0:    w_wbyte = r_wdata[7:0];
      2'd1:    w_wbyte = r_wdata[15:8];
      2'd2:    w_wbyte = r_wdata[23:16];
      default: w_wbyte = r_wdata[31:24];
    endcase
    w_buf_nxt = r_buf;
    w_buf_nxt[{r_recv_cnt[1:0], 3'b000} +: 8] = ram_din_i;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) r_state <= S_IDLE;
    else     r_state <= w_state_nxt;
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_grant) w_state_nxt = S_XFER;
      S_XFER: begin
        if (w_flush_if)                  w_state_nxt = S_IDLE;
        else if (w_wr_last || w_rd_last) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    busy_o      = (r_state != S_IDLE);
    if_done_o   = (r_state == S_DONE) & r_is_if;
    mem_done_o  = (r_state == S_DONE) & ~r_is_if;
    ram_addr_o  = r_ram_addr;
    ram_wr_o    = r_ram_wr;
    ram_dout_o  = r_ram_dout;
    if_data_o   = r_if_data;
    mem_rdata_o = r_mem_rdata;
  end

  // r_addr_vld marks a read address on the port this cycle; r_cap marks its byte arriving now.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_is_if     <= 1'b0;
      r_we        <= 1'b0;
      r_n         <= 3'd0;
      r_base      <= '0;
      r_wdata     <= 32'd0;
      r_issue_cnt <= 3'd0;
      r_recv_cnt  <= 3'd0;
      r_buf       <= 32'd0;
      r_addr_vld  <= 1'b0;
      r_cap       <= 1'b0;
      r_if_data   <= 32'd0;
      r_mem_rdata <= 32'd0;
      r_ram_addr  <= '0;
      r_ram_wr    <= 1'b0;
      r_ram_dout  <= 8'd0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_grant) begin
            r_is_if     <= w_grant_if;
            r_we        <= w_we_sel;
            r_n         <= w_n_sel;
            r_base      <= w_base_sel;
            r_wdata     <= mem_wdata_i;
            r_issue_cnt <= 3'd1;
            r_recv_cnt  <= 3'd0;
            r_buf       <= 32'd0;
            r_ram_addr  <= w_base_sel;
            r_ram_wr    <= w_we_sel;
            r_ram_dout  <= w_we_sel ? mem_wdata_i[7:0] : 8'd0;
            r_addr_vld  <= ~w_we_sel;
          end else begin
            r_ram_addr <= '0;
            r_ram_wr   <= 1'b0;
            r_ram_dout <= 8'd0;
            r_addr_vld <= 1'b0;
          end
          r_cap <= 1'b0;
        end
        S_XFER: begin
          if (w_flush_if) begin
            r_ram_addr <= '0;
            r_ram_wr   <= 1'b0;
            r_ram_dout <= 8'd0;
            r_addr_vld <= 1'b0;
            r_cap      <= 1'b0;
          end else begin
            if (r_issue_cnt < r_n) begin
              r_ram_addr  <= r_base + ADDR_W'(r_issue_cnt);
              r_ram_wr    <= r_we;
              r_ram_dout  <= r_we ? w_wbyte : 8'd0;
              r_addr_vld  <= ~r_we;
              r_issue_cnt <= r_issue_cnt + 3'd1;
            end else begin
              r_ram_addr <= '0;
              r_ram_wr   <= 1'b0;
              r_ram_dout <= 8'd0;
              r_addr_vld <= 1'b0;
            end
            r_cap <= r_addr_vld;
            if (r_cap) begin
              r_buf      <= w_buf_nxt;
              r_recv_cnt <= r_recv_cnt + 3'd1;
            end
            if (w_rd_last) begin
              if (r_is_if) r_if_data   <= w_buf_nxt;
              else         r_mem_rdata <= w_buf_nxt;
            end
          end
        end
        default: begin
          r_ram_addr <= '0;
          r_ram_wr   <= 1'b0;
          r_ram_dout <= 8'd0;
          r_addr_vld <= 1'b0;
          r_cap      <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: byte RAM model, shadow-memory reference, directed and random transactions.
module tb_mem_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic        if_req_i, mem_req_i, mem_we_i, flush_i;
  logic [31:0] if_addr_i, mem_addr_i, mem_wdata_i;
  logic [1:0]  mem_len_i;
  logic        if_done_o, mem_done_o, busy_o, ram_wr_o;
  logic [31:0] if_data_o, mem_rdata_o, ram_addr_o;
  logic [7:0]  ram_dout_o, ram_din_i;

  always #5 clk = ~clk;

  mem_arbiter #(.ADDR_W(32), .MEM_FIRST(1'b1)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_done_o(if_done_o), .if_data_o(if_data_o),
    .mem_req_i(mem_req_i), .mem_we_i(mem_we_i), .mem_len_i(mem_len_i), .mem_addr_i(mem_addr_i),
    .mem_wdata_i(mem_wdata_i), .mem_done_o(mem_done_o), .mem_rdata_o(mem_rdata_o),
    .flush_i(flush_i), .busy_o(busy_o),
    .ram_addr_o(ram_addr_o), .ram_wr_o(ram_wr_o), .ram_dout_o(ram_dout_o), .ram_din_i(ram_din_i)
  );

  // RAM device (only writer of mem) and the bench's own shadow copy of expected contents.
  logic [7:0]  mem     [0:65535];
  logic [7:0]  ref_mem [0:65535];
  logic        ld_en;
  logic [15:0] ld_addr;
  logic [7:0]  ld_data;

  always @(posedge clk) begin
    if (ld_en)         mem[ld_addr] <= ld_data;
    else if (ram_wr_o) mem[ram_addr_o[15:0]] <= ram_dout_o;
    ram_din_i <= mem[ram_addr_o[15:0]];
  end

  int errors = 0;
  int checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic poke(input logic [31:0] a, input logic [7:0] d);
    ld_en = 1'b1; ld_addr = a[15:0]; ld_data = d;
    ref_mem[a[15:0]] = d;
    @(negedge clk);
    ld_en = 1'b0;
  endtask

  // Called at an IDLE-cycle negedge; returns at the IDLE negedge after the done pulse.
  task automatic txn(input bit is_if, input bit we, input logic [1:0] len,
                     input logic [31:0] addr, input logic [31:0] wdata, input string tag);
    int          n, lat, wr_cnt, exp_lat;
    logic [31:0] exp_data, got, a32, wbytes, wmask;
    logic [31:0] tr_addr [0:23];
    logic        tr_wr   [0:23];
    logic [7:0]  tr_dout [0:23];
    logic        other_done;
    n = is_if ? 4 : (len == 2'd0 ? 1 : (len == 2'd1 ? 2 : 4));
    exp_lat  = we ? n + 1 : n + 2;
    exp_data = 32'd0;
    wmask    = 32'd0;
    for (int k = 0; k < n; k++) begin
      a32 = addr + k;
      exp_data[8*k +: 8] = ref_mem[a32[15:0]];
      wmask[8*k +: 8]    = 8'hFF;
    end
    if (is_if) begin
      if_req_i = 1'b1; if_addr_i = addr;
    end else begin
      mem_req_i = 1'b1; mem_we_i = we; mem_len_i = len; mem_addr_i = addr; mem_wdata_i = wdata;
    end
    lat = 0; other_done = 1'b0; got = 32'd0;
    for (int c = 0; c < 24; c++) begin
      tr_addr[c] = 32'd0; tr_wr[c] = 1'b0; tr_dout[c] = 8'd0;
    end
    for (int cyc = 1; cyc <= 20; cyc++) begin
      @(negedge clk);
      tr_addr[cyc] = ram_addr_o; tr_wr[cyc] = ram_wr_o; tr_dout[cyc] = ram_dout_o;
      if (is_if ? mem_done_o : if_done_o) other_done = 1'b1;
      if (is_if ? if_done_o : mem_done_o) begin
        lat = cyc;
        got = is_if ? if_data_o : mem_rdata_o;
        break;
      end
    end
    if_req_i = 1'b0; mem_req_i = 1'b0; mem_we_i = 1'b0;
    chk({tag, "_latency"}, lat, exp_lat);
    chk({tag, "_other_done"}, {31'd0, other_done}, 32'd0);
    for (int k = 0; k < n; k++) chk($sformatf("%s_addr%0d", tag, k), tr_addr[1+k], addr + k);
    chk({tag, "_addr_park"}, tr_addr[n+1], 32'd0);
    wr_cnt = 0; wbytes = 32'd0;
    for (int c = 1; c <= 20; c++) if (tr_wr[c]) wr_cnt++;
    for (int k = 0; k < n; k++) wbytes[8*k +: 8] = tr_dout[1+k];
    chk({tag, "_wr_cycles"}, wr_cnt, we ? n : 0);
    if (we) begin
      chk({tag, "_wbytes"}, wbytes, wdata & wmask);
      for (int k = 0; k < n; k++) begin
        a32 = addr + k;
        ref_mem[a32[15:0]] = wdata[8*k +: 8];
      end
    end else begin
      chk({tag, "_rdata"}, got, exp_data);
    end
    @(negedge clk);
    chk({tag, "_idle_after"}, {31'd0, busy_o}, 32'd0);
  endtask

  initial begin
    int          mcyc, icyc, mcnt, icnt;
    logic [31:0] idat, mdat;
    bit          seen;
    rst = 1'b1; ld_en = 1'b0; ld_addr = 16'd0; ld_data = 8'd0;
    if_req_i = 1'b0; if_addr_i = 32'd0; mem_req_i = 1'b0; mem_we_i = 1'b0;
    mem_len_i = 2'd0; mem_addr_i = 32'd0; mem_wdata_i = 32'd0; flush_i = 1'b0;
    @(negedge clk);
    chk("rst_ctl", {28'd0, if_done_o, mem_done_o, busy_o, ram_wr_o}, 32'd0);
    chk("rst_ram_addr", ram_addr_o, 32'd0);
    chk("rst_ram_dout", {24'd0, ram_dout_o}, 32'd0);
    chk("rst_if_data", if_data_o, 32'd0);
    chk("rst_mem_rdata", mem_rdata_o, 32'd0);
    rst = 1'b0;
    @(negedge clk);

    poke(32'h100, 8'h13); poke(32'h101, 8'h00); poke(32'h102, 8'h00); poke(32'h103, 8'h00);
    poke(32'h31, 8'h80);  poke(32'h32, 8'hFF);  poke(32'h33, 8'h55);
    for (int i = 0; i < 4; i++) poke(32'h200 + i, 8'($urandom));
    for (int i = 0; i < 4; i++) poke(32'h300 + i, 8'($urandom));
    poke(32'hFFFF_FFFE, 8'h11); poke(32'hFFFF_FFFF, 8'h22); poke(32'h0, 8'h33); poke(32'h1, 8'h44);
    for (int i = 0; i < 256; i++) poke(32'h1000 + i, 8'($urandom));

    // Directed single transactions
    txn(1'b1, 1'b0, 2'd2, 32'h100, 32'd0, "fetch_100");
    chk("fetch_100_word", if_data_o, 32'h0000_0013);
    txn(1'b0, 1'b1, 2'd2, 32'h20, 32'hDEAD_BEEF, "store_w20");
    txn(1'b0, 1'b0, 2'd3, 32'h20, 32'd0, "load_w20");
    chk("load_w20_word", mem_rdata_o, 32'hDEAD_BEEF);
    txn(1'b0, 1'b0, 2'd1, 32'h31, 32'd0, "load_h31");
    chk("load_h31_zext", mem_rdata_o, 32'h0000_FF80);
    chk("fetch_data_hold", if_data_o, 32'h0000_0013);

    // Simultaneous requests: MEM byte load wins, IF granted in the IDLE cycle after mem_done
    mem_req_i = 1'b1; mem_we_i = 1'b0; mem_len_i = 2'd0; mem_addr_i = 32'h31;
    if_req_i = 1'b1; if_addr_i = 32'h100;
    mcyc = 0; icyc = 0; mcnt = 0; icnt = 0; idat = 32'd0; mdat = 32'd0;
    for (int cyc = 1; cyc <= 24; cyc++) begin
      @(negedge clk);
      if (mem_done_o) begin
        mcnt++; if (mcyc == 0) mcyc = cyc;
        mdat = mem_rdata_o; mem_req_i = 1'b0;
      end
      if (if_done_o) begin
        icnt++; if (icyc == 0) icyc = cyc;
        idat = if_data_o; if_req_i = 1'b0;
      end
    end
    if_req_i = 1'b0; mem_req_i = 1'b0;
    chk("arb_mem_done_cycle", mcyc, 3);
    chk("arb_if_done_cycle", icyc, 10);
    chk("arb_mem_pulses", mcnt, 1);
    chk("arb_if_pulses", icnt, 1);
    chk("arb_mem_data", mdat, 32'h0000_0080);
    chk("arb_if_data", idat, 32'h0000_0013);

    // Flush in the second XFER cycle of a fetch
    if_req_i = 1'b1; if_addr_i = 32'h200; seen = 1'b0;
    @(negedge clk);
    chk("flush_addr0", ram_addr_o, 32'h200);
    seen |= if_done_o;
    @(negedge clk);
    chk("flush_addr1", ram_addr_o, 32'h201);
    seen |= if_done_o;
    flush_i = 1'b1; if_req_i = 1'b0;
    @(negedge clk);
    flush_i = 1'b0;
    chk("flush_addr_park", ram_addr_o, 32'd0);
    chk("flush_idle", {31'd0, busy_o}, 32'd0);
    for (int cyc = 0; cyc < 8; cyc++) begin
      seen |= if_done_o;
      @(negedge clk);
    end
    chk("flush_no_done", {31'd0, seen}, 32'd0);
    txn(1'b1, 1'b0, 2'd2, 32'h300, 32'd0, "fetch_300");

    // Wrap at the top of the address space
    txn(1'b0, 1'b0, 2'd2, 32'hFFFF_FFFE, 32'd0, "load_wrap");
    chk("load_wrap_word", mem_rdata_o, 32'h4433_2211);

    // Random traffic against the shadow memory
    for (int i = 0; i < 40; i++) begin
      bit          r_if, r_we;
      logic [1:0]  r_len;
      logic [31:0] r_addr;
      r_if   = ($urandom_range(0, 2) == 0);
      r_we   = !r_if && ($urandom_range(0, 1) == 1);
      r_len  = 2'($urandom_range(0, 3));
      r_addr = 32'h1000 + $urandom_range(0, 32'hF0);
      txn(r_if, r_we, r_len, r_addr, $urandom, $sformatf("rnd%0d", i));
    end

    // Reset in the middle of a store
    mem_req_i = 1'b1; mem_we_i = 1'b1; mem_len_i = 2'd2; mem_addr_i = 32'h400; mem_wdata_i = 32'hA5A5_5A5A;
    @(negedge clk);
    @(negedge clk);
    chk("rst_mid_wr_active", {31'd0, ram_wr_o}, 32'd1);
    #1 rst = 1'b1;
    #1;
    chk("rst_mid_wr_async", {31'd0, ram_wr_o}, 32'd0);
    chk("rst_mid_busy", {31'd0, busy_o}, 32'd0);
    mem_req_i = 1'b0; mem_we_i = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    seen = 1'b0;
    for (int cyc = 0; cyc < 6; cyc++) begin
      @(negedge clk);
      seen |= mem_done_o | busy_o | (ram_addr_o != 32'd0);
    end
    chk("rst_mid_quiet", {31'd0, seen}, 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/mem_arbiter.md
Name: mem_arbiter

Overview:
- Owns the single byte-wide RAM port and shares it between two requesters: instruction fetch (IF, 4-byte reads) and the memory stage (MEM, 1/2/4-byte loads and stores).
- Breaks each request into byte accesses, issuing one address per cycle, and reassembles little-endian read data.
- Returns a one-cycle done pulse to the requester that was served.
- Sits between the IF/MEM stages and the RAM, and sequences every RAM transaction in the core.

Parameters:
ADDR_W, 32, width of all address ports and internal address arithmetic
MEM_FIRST, 1, 1 = MEM wins a simultaneous IDLE-cycle request; 0 = IF wins

Ports:
clk  input  1  system clock
rst  input  1  reset; asynchronous, active-high
if_req_i  input  1  IF request level; held until if_done_o
if_addr_i  input  ADDR_W  fetch address; byte 0 at this address
if_done_o  output  1  one-cycle pulse; if_data_o valid in the same cycle
if_data_o  output  32  fetched word, {b3,b2,b1,b0}
mem_req_i  input  1  MEM request level; held until mem_done_o
mem_we_i  input  1  1 = store, 0 = load
mem_len_i  input  2  00 = byte, 01 = half, 10/11 = word
mem_addr_i  input  ADDR_W  access address
mem_wdata_i  input  32  store data; byte k written to addr+k
mem_done_o  output  1  one-cycle pulse at completion (loads and stores)
mem_rdata_o  output  32  load data, zero-extended raw bytes; MEM stage sign-extends
flush_i  input  1  branch flush; cancels IF work only
busy_o  output  1  high in any state other than IDLE
ram_addr_o  output  ADDR_W  RAM byte address (registered)
ram_wr_o  output  1  RAM write enable (registered)
ram_dout_o  output  8  RAM write data (registered)
ram_din_i  input  8  RAM read data; holds mem[A] the cycle after A is on ram_addr_o

Behaviour:
- Reset (asynchronous): go to IDLE. Force all outputs to 0 and clear the counters and byte buffers. Reset mid-transaction abandons the transaction with no done pulse.
- States are IDLE, XFER and DONE. Counters: issue_cnt (bytes issued) and recv_cnt (bytes captured). Byte count n is 4 for IF and 1/2/4 for MEM.
- IDLE: ram_addr_o = 0, ram_wr_o = 0, ram_dout_o = 0.
- IDLE grant rules:
  - Only mem_req_i high: grant MEM.
  - Only if_req_i high and flush_i low: grant IF.
  - Both high: grant per MEM_FIRST.
  - if_req_i with flush_i high is not granted that cycle.
- On a grant, latch requester, address, we, n and wdata, then go to XFER.
- Requests are ignored in any cycle where if_done_o or mem_done_o is high, so a still-held req cannot retrigger.
- XFER issue: in the k-th XFER cycle (k = 0..n-1), drive ram_addr_o = base + k, computed modulo 2^ADDR_W (wrap at top of address space is legal). Stores also drive ram_wr_o = 1 and ram_dout_o = wdata byte k. Once k = n, drive ram_addr_o = 0 and ram_wr_o = 0.
- XFER capture (reads): ram_din_i is sampled one cycle after each address. Byte k goes to lane k; lanes at or above n are 0.
- Read completion: after the last byte is captured, go to DONE. Read latency is grant cycle G, addresses in G+1..G+n, done pulse in cycle G+n+2.
- Write completion: after the last write cycle, go to DONE. Done pulse in cycle G+n+1.
- DONE (1 cycle): pulse the served requester's done output; its data output is valid in this cycle. Go to IDLE next cycle.
- Data output hold: if_data_o and mem_rdata_o hold their values until that requester's next completion.
- Flush:
  - flush_i high while serving IF in XFER: stop issuing and drive ram_addr_o = 0 next cycle. Discard in-flight data, return to IDLE with no if_done_o.
  - flush_i high during a MEM transaction or in DONE for MEM: no effect.
  - flush_i high in DONE for IF: the pulse still occurs; the IF stage discards it.
- The other requester waits. Its req stays high, and it is granted on the first eligible IDLE cycle.
- busy_o = (state != IDLE).

Test Plan:
1. IF fetch at 0x100, RAM[0x100..0x103] = 13,00,00,00 -> ram_addr_o 0x100..0x103 in consecutive cycles; if_done_o pulses at G+6 with if_data_o = 0x00000013; ram_wr_o stays 0.
2. MEM store word 0xDEADBEEF at 0x20 -> writes EF,BE,AD,DE to 0x20..0x23 with ram_wr_o = 1 for exactly 4 cycles; mem_done_o at G+5; a readback load word returns 0xDEADBEEF.
3. MEM load half at 0x31, RAM = 0x80,0xFF -> mem_rdata_o = 0x0000FF80 (no sign extension); exactly 2 addresses issued; mem_done_o at G+4.
4. if_req_i and mem_req_i rise in the same IDLE cycle, MEM_FIRST = 1 -> MEM served first; IF granted on the first IDLE cycle after mem_done_o; exactly one done pulse each; no retrigger while reqs are held.
5. IF fetch at 0x200 with flush_i pulsed in the 2nd XFER cycle -> at most 2 addresses issued; no if_done_o; IDLE next cycle; a new fetch at 0x300 completes normally.
6. Load word at 0xFFFFFFFE -> addresses FFFFFFFE, FFFFFFFF, 0, 1; asserting rst mid-store -> ram_wr_o drops to 0 asynchronously, no done pulse, IDLE after release.
